// File: rtl/micro_pkg.sv
// Shared types and constants for the parametrised accumulator micro.
package micro_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    WAIT_IN  = 2'b01,
    WAIT_OUT = 2'b10
  } state_e;

  localparam int SLOT_IO = 0;
  localparam int SLOT_A  = 1;

endpackage

// File: rtl/micro_alu.sv
// Combinational ADD/SUB/CMP unit computed at WIDTH+1 bits.
module micro_alu
  import micro_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c
);

  logic [WIDTH:0] wide;

  always_comb begin
    wide   = '0;
    result = b;
    z      = 1'b0;
    c      = 1'b0;
    unique case (op)
      OP_MOV: result = b;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[WIDTH-1:0];
        c      = wide[WIDTH];
        z      = (result == '0);
      end
      OP_SUB, OP_CMP: begin
        // top bit of the extended difference is the borrow (a < b)
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[WIDTH-1:0];
        c      = wide[WIDTH];
        z      = (result == '0);
      end
    endcase
  end

endmodule

// File: rtl/micro_param.sv
// Single-accumulator micro with register file and valid/ready I/O channels.
module micro_param
  import micro_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int RW = $clog2(NREGS),
  localparam int INST_W = 2 + 2 * RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              flag_z,
  output logic              flag_c,
  output logic [WIDTH-1:0]  acc
);

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d, cur;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  rf_q [NREGS];
  logic [WIDTH-1:0]  rf_d [NREGS];
  logic              dov_q, dov_d;
  logic              z_q, z_d, c_q, c_d;
  logic [WIDTH-1:0]  opnd, alu_res;
  logic              alu_z, alu_c, exec;
  op_e               op;
  logic [RW-1:0]     dst, src;

  // In WAIT_IN the latched instruction drives decode
  assign cur = (state_q == WAIT_IN) ? inst_q : inst;
  assign op  = op_e'(cur[INST_W-1 -: 2]);
  assign dst = cur[2*RW-1 -: RW];
  assign src = cur[RW-1:0];

  always_comb begin
    opnd = rf_q[src];
    unique case (1'b1)
      (src == RW'(SLOT_IO)): opnd = data_in;
      (src == RW'(SLOT_A)):  opnd = acc_q;
      default:               opnd = rf_q[src];
    endcase
  end

  micro_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (acc_q),
    .b      (opnd),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    acc_d         = acc_q;
    rf_d          = rf_q;
    dout_d        = dout_q;
    dov_d         = dov_q;
    z_d           = z_q;
    c_d           = c_q;
    inst_ready    = 1'b0;
    data_in_ready = 1'b0;
    exec          = 1'b0;
    unique case (state_q)
      RUN: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          if (src == RW'(SLOT_IO)) begin
            data_in_ready = data_in_valid;
            exec          = data_in_valid;
            if (!data_in_valid) begin
              inst_d  = inst;
              state_d = WAIT_IN;
            end
          end else begin
            exec = 1'b1;
          end
        end
      end
      WAIT_IN: begin
        data_in_ready = 1'b1;
        exec          = data_in_valid;
        if (data_in_valid) state_d = RUN;
      end
      WAIT_OUT: begin
        if (data_out_ready) begin
          dov_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (exec) begin
      unique case (op)
        OP_MOV: begin
          unique case (1'b1)
            (dst == RW'(SLOT_IO)): begin
              dout_d  = opnd;
              dov_d   = 1'b1;
              state_d = WAIT_OUT;
            end
            (dst == RW'(SLOT_A)): acc_d = opnd;
            default:              rf_d[dst] = opnd;
          endcase
        end
        OP_ADD, OP_SUB: begin
          acc_d = alu_res;
          z_d   = alu_z;
          c_d   = alu_c;
        end
        OP_CMP: begin
          z_d = alu_z;
          c_d = alu_c;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      inst_q  <= '0;
      acc_q   <= '0;
      rf_q    <= '{default: '0};
      dout_q  <= '0;
      dov_q   <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      acc_q   <= acc_d;
      rf_q    <= rf_d;
      dout_q  <= dout_d;
      dov_q   <= dov_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dov_q;
  assign flag_z         = z_q;
  assign flag_c         = c_q;
  assign acc            = acc_q;

endmodule
